nibble_serial_logic_ctrl: RTL and testbench

Sequencer that computes a 32-bit bitwise logic result (AND/OR/XOR/NOR) by time-multiplexing one 4-bit logic slice over 8 clock cycles, least-significant nibble first. It is the area-reduced alternative to the fully parallel 32-bit logic datapath, for the multi-cycle core variant. It owns operand capture, the slice counter, result assembly and a start/done handshake toward the main control FSM.

---
 rtl/nibble_serial_logic_ctrl.sv | 167 ++++++++++++++++
 tb/tb_nibble_serial_logic_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_logic_ctrl.sv
// -----------------------------------------------------------------------------
// nibble_serial_logic_ctrl
//
// Computes a WIDTH-bit bitwise logic result (AND / OR / XOR / NOR) by reusing
// one SLICE-bit logic slice over WIDTH/SLICE clock cycles, least-significant
// slice first. Operands and the operation code are captured when a request
// is accepted. The result is assembled in an internal accumulator and is
// copied to R only on the completion edge, so partial results never appear
// on R.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request a new operation (sampled only while ready=1)
//   op         00 AND, 01 OR, 10 XOR, 11 NOR (captured with start)
//   A, B       operands (captured with start)
//   abort      cancel the in-flight operation (only meaningful in RUN)
//   ready      block can accept start this cycle (IDLE or DONE)
//   busy       operation in progress (RUN)
//   done       one-cycle pulse: R holds a new result (DONE)
//   slice_idx  slice currently being processed (observability)
//   R          last completed result
// -----------------------------------------------------------------------------
module nibble_serial_logic_ctrl #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             abort,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] slice_idx,
  output logic [WIDTH-1:0] R
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [1:0]       op_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] r_reg;
  logic [CNT_W-1:0] slice_idx_reg;

  // Captured operands split into slices so the shared slice can pick one by
  // index instead of a variable part-select.
  logic [SLICE-1:0] a_slice [NSLICE];
  logic [SLICE-1:0] b_slice [NSLICE];
  logic [SLICE-1:0] a_cur;
  logic [SLICE-1:0] b_cur;
  logic [SLICE-1:0] slice_res;
  logic [WIDTH-1:0] acc_next;

  genvar gi;
  generate
    for (gi = 0; gi < NSLICE; gi++) begin : g_slice
      assign a_slice[gi] = a_reg[gi*SLICE +: SLICE];
      assign b_slice[gi] = b_reg[gi*SLICE +: SLICE];
      // Accumulator with the current slice merged in. The completion edge
      // copies this (not acc_reg) into R so the last slice is included.
      assign acc_next[gi*SLICE +: SLICE] =
        (slice_idx_reg == CNT_W'(gi)) ? slice_res : acc_reg[gi*SLICE +: SLICE];
    end
  endgenerate

  always_comb begin
    a_cur = '0;
    b_cur = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (slice_idx_reg == CNT_W'(i)) begin
        a_cur = a_slice[i];
        b_cur = b_slice[i];
      end
    end
  end

  // The single shared logic slice.
  always_comb begin
    slice_res = '0;
    unique case (op_reg)
      2'b00:   slice_res = a_cur & b_cur;
      2'b01:   slice_res = a_cur | b_cur;
      2'b10:   slice_res = a_cur ^ b_cur;
      default: slice_res = ~(a_cur | b_cur);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      op_reg        <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      acc_reg       <= '0;
      r_reg         <= '0;
      slice_idx_reg <= '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (start) begin
            op_reg        <= op;
            a_reg         <= A;
            b_reg         <= B;
            slice_idx_reg <= '0;
            state_reg     <= RUN;
          end
        end
        RUN: begin
          // start is ignored here: there is no request queueing.
          if (abort) begin
            slice_idx_reg <= '0;
            state_reg     <= IDLE;
          end else begin
            acc_reg <= acc_next;
            if (slice_idx_reg == LAST_IDX) begin
              r_reg         <= acc_next;
              slice_idx_reg <= '0;
              state_reg     <= DONE;
            end else begin
              slice_idx_reg <= slice_idx_reg + 1'b1;
            end
          end
        end
        DONE: begin
          // A start in the DONE cycle wins over abort, which has no effect here.
          if (start) begin
            op_reg        <= op;
            a_reg         <= A;
            b_reg         <= B;
            slice_idx_reg <= '0;
            state_reg     <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end
        default: begin
          slice_idx_reg <= '0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  // Handshake outputs are decoded straight from the state register, so they
  // are glitch-free and follow the asynchronous reset immediately.
  assign ready     = (state_reg == IDLE) || (state_reg == DONE);
  assign busy      = (state_reg == RUN);
  assign done      = (state_reg == DONE);
  assign slice_idx = slice_idx_reg;
  assign R         = r_reg;

endmodule

// File: tb/tb_nibble_serial_logic_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for nibble_serial_logic_ctrl. Stimulus pushes the expected result
// and completion cycle of each accepted request into queues; a monitor pops
// and compares whenever done is presented.
// -----------------------------------------------------------------------------
module tb_nibble_serial_logic_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        abort = 1'b0;
  logic        ready;
  logic        busy;
  logic        done;
  logic [2:0]  slice_idx;
  logic [31:0] R;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] exp_q [$];
  int          cyc_q [$];

  nibble_serial_logic_ctrl #(.WIDTH(32), .SLICE(4), .CNT_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .A         (A),
    .B         (B),
    .abort     (abort),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .slice_idx (slice_idx),
    .R         (R)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with R=%h expected no done", R);
      end else begin
        logic [31:0] e;
        int          c;
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        $display("txn done R=%h expected %h cycle %0d expected %0d", R, e, cyc, c);
        check("result_R", R, e);
        check("done_cycle", 32'(cyc), 32'(c));
      end
    end
  end

  // Called at a negedge with ready=1; returns one cycle later (start dropped).
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expv, input bit expect_done);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    if (expect_done) begin
      exp_q.push_back(expv);
      cyc_q.push_back(cyc + 9);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: done not seen, got done=%b expected 1 within 20 cycles", name, done);
    end
  endtask

  initial begin
    // Reset then idle.
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_R", R, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_ready", 32'(ready), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("idle_R", R, 32'h0);
    end

    // XOR with per-cycle observation of slice_idx and R stability.
    issue(2'b10, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b1);
    for (int k = 0; k < 8; k++) begin
      check("run_busy", 32'(busy), 32'd1);
      check("run_ready", 32'(ready), 32'd0);
      check("run_slice_idx", 32'(slice_idx), 32'(k));
      check("run_R_stable", R, 32'h0);
      @(negedge clk);
    end
    check("xor_done", 32'(done), 32'd1);
    check("xor_ready_in_done", 32'(ready), 32'd1);
    @(negedge clk);
    check("xor_back_idle_done", 32'(done), 32'd0);

    // Operands change right after acceptance.
    issue(2'b00, 32'h12345678, 32'hFFFFFFFF, 32'h12345678, 1'b1);
    A = '0;
    B = '0;
    wait_done("and_capture");
    @(negedge clk);

    // Back-to-back via the DONE cycle.
    issue(2'b01, 32'h00000001, 32'h80000000, 32'h80000001, 1'b1);
    wait_done("b2b_first");
    issue(2'b11, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b1);
    wait_done("b2b_second");
    @(negedge clk);

    // start during RUN is ignored.
    issue(2'b00, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b1);
    @(negedge clk);
    start = 1'b1; op = 2'b10; A = 32'hDEADBEEF; B = 32'h01234567;
    @(negedge clk);
    start = 1'b0;
    wait_done("start_ignored");
    @(negedge clk);

    // Abort at slice_idx=3.
    issue(2'b10, 32'h12345678, 32'h87654321, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    check("abort_at_idx", 32'(slice_idx), 32'd3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_slice_idx", 32'(slice_idx), 32'd0);
    check("abort_R_kept", R, 32'hF000F000);
    repeat (12) @(negedge clk);
    check("abort_R_later", R, 32'hF000F000);

    // Asynchronous reset mid-RUN at slice_idx=5.
    issue(2'b01, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0);
    repeat (5) @(negedge clk);
    check("arst_at_idx", 32'(slice_idx), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(ready), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_slice_idx", 32'(slice_idx), 32'd0);
    check("arst_R", R, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(2'b00, 32'hAAAAAAAA, 32'h5555FFFF, 32'h0000AAAA, 1'b1);
    wait_done("after_reset");
    repeat (3) @(negedge clk);

    check("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
